// File: rtl/pes_fp_div.sv
// Single-precision divider: 25-cycle restoring mantissa division, then one normalise/pack cycle.
// Exponent-field-zero operands are treated as zero; divide-by-zero saturates to signed infinity.
module pes_fp_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] F,
  output logic        dbz
);

  typedef enum logic [1:0] {IDLE, CALC, NORM} state_t;

  state_t             state_q;
  logic [4:0]         cnt_q;
  logic [24:0]        rem_q, rem_d;
  logic [23:0]        div_q;
  logic [24:0]        q_q, q_d;
  logic signed [9:0]  exp_q;
  logic               sign_q, azero_q, bzero_q;
  logic               busy_q, done_q, dbz_q;
  logic [31:0]        f_q;

  logic               qbit;
  logic [24:0]        rem_sub;
  logic signed [9:0]  exp_acc;
  logic signed [9:0]  exp_norm;
  logic [22:0]        mant_norm;
  logic [31:0]        result_d;

  function automatic logic [31:0] pack_result(input logic sign,
                                              input logic signed [9:0] e,
                                              input logic [22:0] m);
    if (e >= 10'sd255)
      return {sign, 8'hFF, 23'h0};
    else if (e <= 10'sd0)
      return {sign, 31'h0};
    else
      return {sign, e[7:0], m};
  endfunction

  always_comb begin
    qbit     = (rem_q >= {1'b0, div_q});
    rem_sub  = qbit ? (rem_q - {1'b0, div_q}) : rem_q;
    rem_d    = rem_sub << 1;
    q_d      = {q_q[23:0], qbit};
    exp_acc  = signed'({2'b00, A[30:23]}) - signed'({2'b00, B[30:23]}) + 10'sd127;
    // Quotient lies in (0.5, 2): q[24] tells which binade it landed in.
    if (q_q[24]) begin
      mant_norm = q_q[23:1];
      exp_norm  = exp_q;
    end else begin
      mant_norm = q_q[22:0];
      exp_norm  = exp_q - 10'sd1;
    end
    if (bzero_q)
      result_d = {sign_q, 8'hFF, 23'h0};
    else if (azero_q)
      result_d = {sign_q, 31'h0};
    else
      result_d = pack_result(sign_q, exp_norm, mant_norm);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      div_q   <= '0;
      q_q     <= '0;
      exp_q   <= '0;
      sign_q  <= 1'b0;
      azero_q <= 1'b0;
      bzero_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      f_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= CALC;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            rem_q   <= {2'b01, A[22:0]};
            div_q   <= {1'b1, B[22:0]};
            q_q     <= '0;
            exp_q   <= exp_acc;
            sign_q  <= A[31] ^ B[31];
            azero_q <= (A[30:23] == 8'h00);
            bzero_q <= (B[30:23] == 8'h00);
          end
        end
        CALC: begin
          rem_q <= rem_d;
          q_q   <= q_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd24)
            state_q <= NORM;
        end
        NORM: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          f_q     <= result_d;
          dbz_q   <= bzero_q;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign F    = f_q;
  assign dbz  = dbz_q;

endmodule

// File: tb/tb_pes_fp_div.sv
// Directed bench for pes_fp_div: hand-computed quotients, latency, start masking and reset abort.
module tb_pes_fp_div;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        busy, done, dbz;
  logic [31:0] F;

  int tests = 0;
  int failed = 0;

  pes_fp_div dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .busy(busy), .done(done), .F(F), .dbz(dbz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive start for one edge; returns 1ns after the sampling edge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    A = a;
    B = b;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Expects done exactly lat edges from now, then checks F and dbz.
  task automatic wait_done(input string tag, input int lat,
                           input logic [31:0] expf, input logic expdbz);
    int k;
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        k = i;
        break;
      end
    end
    chk({tag, "_lat"}, k, lat);
    chk({tag, "_F"}, F, expf);
    chk({tag, "_dbz"}, {31'h0, dbz}, {31'h0, expdbz});
    chk({tag, "_busy_lo"}, {31'h0, busy}, 32'h0);
  endtask

  task automatic count_dones(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) n++;
    end
  endtask

  initial begin
    int n;
    rst = 1'b1;
    #1;
    chk("rst_F", F, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_dbz", {31'h0, dbz}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // 6 / 2 = 3
    start_op(32'h40C00000, 32'h40000000);
    chk("div6_busy", {31'h0, busy}, 32'h1);
    wait_done("div6", 26, 32'h40400000, 1'b0);
    @(posedge clk);
    #1 chk("div6_done_pulse", {31'h0, done}, 32'h0);
    chk("div6_F_hold", F, 32'h40400000);

    start_op(32'h3F800000, 32'h40400000);
    wait_done("third", 26, 32'h3EAAAAAA, 1'b0);
    start_op(32'hC1000000, 32'h3F000000);
    wait_done("m8_half", 26, 32'hC1800000, 1'b0);
    start_op(32'hC0C00000, 32'h40000000);
    wait_done("m6_2", 26, 32'hC0400000, 1'b0);

    start_op(32'h3F800000, 32'h00000000);
    wait_done("dbz", 26, 32'h7F800000, 1'b1);
    start_op(32'h3F800000, 32'h80000000);
    wait_done("dbz_neg", 26, 32'hFF800000, 1'b1);
    start_op(32'h00000000, 32'h00000000);
    wait_done("dbz_zz", 26, 32'h7F800000, 1'b1);
    start_op(32'h00000000, 32'h40000000);
    wait_done("azero", 26, 32'h00000000, 1'b0);
    start_op(32'h80000000, 32'h40000000);
    wait_done("azero_neg", 26, 32'h80000000, 1'b0);

    start_op(32'h7F000000, 32'h00800000);
    wait_done("ovf", 26, 32'h7F800000, 1'b0);
    start_op(32'h00800000, 32'h7F000000);
    wait_done("unf", 26, 32'h00000000, 1'b0);

    // Second start at N+5 must be ignored.
    start_op(32'h40C00000, 32'h40000000);
    repeat (4) @(posedge clk);
    A = 32'h3F800000;
    B = 32'h40400000;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("ignore", 21, 32'h40400000, 1'b0);

    // Back-to-back: start raised while done is high.
    A = 32'hC1000000;
    B = 32'h3F000000;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("b2b_busy", {31'h0, busy}, 32'h1);
    chk("b2b_done_lo", {31'h0, done}, 32'h0);
    wait_done("b2b", 26, 32'hC1800000, 1'b0);
    count_dones(40, n);
    chk("b2b_no_extra", n, 0);

    // Reset at N+10 aborts the operation.
    start_op(32'h3F800000, 32'h40400000);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_F", F, 32'h0);
    chk("abort_busy", {31'h0, busy}, 32'h0);
    chk("abort_done", {31'h0, done}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    count_dones(40, n);
    chk("abort_no_done", n, 0);
    start_op(32'h40C00000, 32'h40000000);
    wait_done("post_rst", 26, 32'h40400000, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
